// File: rtl/gpio_serial_loader.sv
// Serial configuration loader: shifts one CFG_BITS word per GPIO pad, highest pad first, then strobes serial_load.
// Build macro GPIO_LOADER_CLKDIV_EN adds a clk_div input that stretches every shift/load phase to clk_div+1 cycles.
module gpio_serial_loader #(
    parameter int NUM_PADS = 38,
    parameter int CFG_BITS = 13,
    localparam int IDX_W = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1,
    localparam int BIT_W = (CFG_BITS > 1) ? $clog2(CFG_BITS) : 1
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                xfer_start,
    input  logic [CFG_BITS-1:0] cfg_word,
`ifdef GPIO_LOADER_CLKDIV_EN
    input  logic [3:0]          clk_div,
`endif
    output logic [IDX_W-1:0]    cfg_index,
    output logic                busy,
    output logic                done,
    output logic                serial_clock,
    output logic                serial_data,
    output logic                serial_load
);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LOAD,
        FINISH
    } state_t;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_PADS - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CFG_BITS - 1);

    state_t                state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [3:0]            ph_q, ph_d;
    logic [3:0]            ph_max;
    logic [CFG_BITS-1:0]   shadow_q, shadow_d;
    logic                  sclk_q, sclk_d;
    logic                  sdata_q, sdata_d;
    logic                  sload_q, sload_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  first_bit;
    logic                  ph_last;

`ifdef GPIO_LOADER_CLKDIV_EN
    logic [3:0]            ph_max_q, ph_max_d;
    assign ph_max = ph_max_q;
`else
    assign ph_max = 4'd0;
`endif

    // cfg_index already points at the pad during its first SHIFT_LO cycle, so the word is captured there.
    assign first_bit = (state_q == SHIFT_LO) && (bit_q == BIT_LAST) && (ph_q == 4'd0);
    assign ph_last   = (ph_q == ph_max);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        bit_d    = bit_q;
        ph_d     = ph_q;
`ifdef GPIO_LOADER_CLKDIV_EN
        ph_max_d = ph_max_q;
`endif
        shadow_d = first_bit ? cfg_word : shadow_q;
        sdata_d  = sdata_q;
        if (state_q == SHIFT_LO) begin
            sdata_d = shadow_d[bit_q];
        end

        case (state_q)
            IDLE: begin
                // done_q marks the visible completion cycle; a start there is dropped, not queued.
                if (xfer_start && !done_q) begin
                    state_d  = SHIFT_LO;
                    idx_d    = IDX_LAST;
                    bit_d    = BIT_LAST;
                    ph_d     = 4'd0;
`ifdef GPIO_LOADER_CLKDIV_EN
                    ph_max_d = clk_div;
`endif
                end
            end
            SHIFT_LO: begin
                if (ph_last) begin
                    ph_d    = 4'd0;
                    state_d = SHIFT_HI;
                end else begin
                    ph_d = ph_q + 4'd1;
                end
            end
            SHIFT_HI: begin
                if (ph_last) begin
                    ph_d = 4'd0;
                    if (bit_q != '0) begin
                        bit_d   = bit_q - BIT_W'(1);
                        state_d = SHIFT_LO;
                    end else if (idx_q != '0) begin
                        idx_d   = idx_q - IDX_W'(1);
                        bit_d   = BIT_LAST;
                        state_d = SHIFT_LO;
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
                    ph_d = ph_q + 4'd1;
                end
            end
            LOAD: begin
                if (ph_last) begin
                    ph_d    = 4'd0;
                    state_d = FINISH;
                end else begin
                    ph_d = ph_q + 4'd1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Pin outputs are a registered image of the current state, one cycle behind it.
        sclk_d  = (state_q == SHIFT_HI);
        sload_d = (state_q == LOAD);
        busy_d  = (state_q == SHIFT_LO) || (state_q == SHIFT_HI) || (state_q == LOAD);
        done_d  = (state_q == FINISH);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            bit_q    <= '0;
            ph_q     <= 4'd0;
            shadow_q <= '0;
            sclk_q   <= 1'b0;
            sdata_q  <= 1'b0;
            sload_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            bit_q    <= bit_d;
            ph_q     <= ph_d;
            shadow_q <= shadow_d;
            sclk_q   <= sclk_d;
            sdata_q  <= sdata_d;
            sload_q  <= sload_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

`ifdef GPIO_LOADER_CLKDIV_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ph_max_q <= 4'd0;
        end else begin
            ph_max_q <= ph_max_d;
        end
    end
`endif

    assign cfg_index    = idx_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign serial_clock = sclk_q;
    assign serial_data  = sdata_q;
    assign serial_load  = sload_q;

endmodule
